pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for datapath units that need wide adds at high clock rates. A WIDTH-bit operation is split into STAGES equal segments. Each pipeline stage resolves one segment with grouped CLA logic and registers the carry into the next stage. A valid/ready handshake on both sides gives full-throughput streaming with backpressure.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth in cycles; segment width SEG = WIDTH/STAGES.
GROUP, 4, CLA group size inside a segment; SEG must be a multiple of GROUP.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an input this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (borrow-in when sub=1, see below)
sub  in  1  1 = subtract (a - b), 0 = add
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry-out of MSB (in sub mode: 1 = no borrow)

Behaviour:
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = cin ^ sub. So sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Arithmetic: {cout,sum} = a + b_eff + c0, modulo 2^(WIDTH+1).
- Stage s (0..STAGES-1) computes sum[s*SEG +: SEG] and its segment carry-out from the registered carry of stage s-1 (c0 for s=0), using SEG/GROUP CLA groups.
- Group carries inside a segment use lookahead (group G/P); no bit-ripple inside a group.
- Each stage registers: its valid bit, the carry-out, the sum bits already produced, and the not-yet-consumed upper bits of a and b_eff.
- Latency: exactly STAGES cycles from input handshake (in_valid & in_ready) to out_valid, when out_ready is held high.
- Throughput: one operation per cycle when out_ready=1.
- Handshake, per stage: ready_s = ~valid_s | ready_(s+1), with ready_STAGES = out_ready.
  - in_ready = ready_0.
  - Stage s loads when ready_s is high.
  - valid_s takes the upstream valid when loading; otherwise it holds.
  - in_ready is combinational from out_ready; there are no bubbles.
- Stall: while out_valid=1 and out_ready=0, sum/cout/out_valid hold stable. Upstream stages fill until in_ready=0.
- A full pipeline (STAGES operations in flight) with out_ready=0 gives in_ready=0. An input presented then is not accepted and must be held by the source.
- Simultaneous output pop and input push on a full pipeline: both occur in the same cycle and occupancy is unchanged.
- Order is strictly preserved; no drop, no duplication.
- Reset (async assert, sync-released by the system):
  - all valid bits 0, so out_valid=0 and in_ready=1;
  - sum=0, cout=0, all data and carry registers 0.
- Reset mid-operation discards every in-flight operation.
- Data registers need not be cleared when their valid bit is 0, but outputs must read 0 after reset until the first result.

Optional Feature:
Macro PIPELINED_CLA_FLAGS_EN.
- Defined: adds output ports ovf (1 bit) and zero (1 bit), registered alongside sum and 0 after reset.
  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), the signed overflow.
  - zero = (sum == 0).
  - The needed MSBs are carried through the pipeline.
- Undefined: ports absent; no extra registers.

Decomposition:
- Package pipelined_cla_pkg holds:
  - constant helpers for SEG = WIDTH/STAGES and NGRP = SEG/GROUP;
  - a parameter-legality check function, elaborated so that WIDTH%STAGES != 0 or SEG%GROUP != 0 is fatal.
- Sub-module cla_group: combinational GROUP-bit CLA.
  - Inputs: a, b, cin.
  - Outputs: sum, group generate G, group propagate P, cout.
  - Instantiated NGRP times per stage.

Test Plan:
- Carry across all stages: WIDTH=32/STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, out_valid exactly 4 cycles after the accept.
- Subtraction: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0. With the flags macro: ovf=0, zero=0.
- Signed overflow (macro on): a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0. Also a=b=0x12345678, sub=1 -> sum=0, zero=1, cout=1.
- Backpressure: stream 16 random ops back-to-back with out_ready random 50% -> results match the reference model in order. in_ready drops only after 4 outputs are stalled. No loss or duplication.
- Full-pipe simultaneous push/pop: fill 4 ops, then raise out_ready while in_valid=1 -> in_ready=1 that cycle and occupancy stays 4.
- Reset mid-stream: 3 ops in flight, pulse rst_n low -> out_valid=0, sum=0, cout=0 and in_ready=1 immediately. No stale result appears after release.

Source files
------------

// File: rtl/pipelined_cla_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pipelined_cla_pkg
// Description : Shared constants and elaboration helpers for the pipelined
//               carry-lookahead adder/subtractor (segment/group sizing and
//               parameter legality).
// Revision    : 1.0 - initial release
//==============================================================================
package pipelined_cla_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;
   localparam int DEF_GROUP  = 4;

   // Bits resolved by one pipeline stage.
   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   // CLA groups inside one segment.
   function automatic int num_groups(input int seg, input int group);
      return seg / group;
   endfunction

   // Width must split evenly into stages, and each segment into groups.
   function automatic bit params_legal(input int width, input int stages, input int group);
      return (width > 0) && (stages > 0) && (group > 0) &&
             ((width % stages) == 0) && (((width / stages) % group) == 0);
   endfunction

endpackage : pipelined_cla_pkg
`default_nettype wire

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
//==============================================================================
// Module      : pipelined_cla_adder_if
// Description : Operand/result streaming bus of the pipelined CLA adder.
//               slave = adder side, master = producer/consumer side.
//               Macro PIPELINED_CLA_FLAGS_EN adds the ovf/zero flags.
// Revision    : 1.0 - initial release
//==============================================================================
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPELINED_CLA_FLAGS_EN
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );
`else
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );
`endif
endinterface : pipelined_cla_adder_if
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_group.sv
`default_nettype none
//==============================================================================
// Module      : cla_group
// Description : Combinational GROUP-bit carry-lookahead block. Every internal
//               carry is a flat sum of products of generate/propagate terms,
//               so there is no bit-to-bit ripple. Exposes group G/P for the
//               next lookahead level.
// Revision    : 1.0 - initial release
//==============================================================================
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] i_a,
   input  logic [GROUP-1:0] i_b,
   input  logic             i_cin,
   output logic [GROUP-1:0] o_sum,
   output logic             o_g,
   output logic             o_p,
   output logic             o_cout
);
   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_c;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Bit carries c[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & cin).
   always_comb begin
      logic v_term;
      logic v_acc_p;
      w_c    = '0;
      w_c[0] = i_cin;
      for (int i = 1; i < GROUP; i++) begin
         v_term  = 1'b0;
         v_acc_p = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            v_term  = v_term | (v_acc_p & w_g[j]);
            v_acc_p = v_acc_p & w_p[j];
         end
         w_c[i] = v_term | (v_acc_p & i_cin);
      end
   end

   // Group generate: a carry leaves the group regardless of its carry-in.
   always_comb begin
      logic v_acc_p;
      o_g     = 1'b0;
      v_acc_p = 1'b1;
      for (int j = GROUP - 1; j >= 0; j--) begin
         o_g     = o_g | (v_acc_p & w_g[j]);
         v_acc_p = v_acc_p & w_p[j];
      end
   end

   assign o_p    = &w_p;
   assign o_sum  = w_p ^ w_c;
   assign o_cout = o_g | (o_p & i_cin);

endmodule : cla_group
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
//==============================================================================
// Module      : pipelined_cla_adder
// Description : STAGES-deep pipelined carry-lookahead adder/subtractor. Stage
//               s resolves bits [s*SEG +: SEG] with NGRP cla_group blocks plus
//               a group-level lookahead, then registers the carry, the sum
//               produced so far and the remaining operand bits. Valid/ready
//               per stage gives full throughput with backpressure.
//               Optional macro: PIPELINED_CLA_FLAGS_EN (ovf/zero outputs).
// Revision    : 1.0 - initial release
//==============================================================================
module pipelined_cla_adder
   import pipelined_cla_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int GROUP  = DEF_GROUP
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipelined_cla_adder_if.slave  bus
);
   localparam int SEG  = seg_width(WIDTH, STAGES);
   localparam int NGRP = num_groups(SEG, GROUP);

   if (!params_legal(WIDTH, STAGES, GROUP)) begin : g_param_check
      $fatal(1, "pipelined_cla_adder: WIDTH must divide by STAGES and SEG by GROUP");
   end

   logic [STAGES-1:0] w_valid;
   logic [STAGES-1:0] w_carry;
   logic [STAGES-1:0] w_ready;
   logic [WIDTH-1:0]  w_sum [STAGES];
   logic [WIDTH-1:0]  w_a   [STAGES];
   logic [WIDTH-1:0]  w_b   [STAGES];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic             w_up_valid;
      logic             w_c_i;
      logic [WIDTH-1:0] w_a_i;
      logic [WIDTH-1:0] w_b_i;
      logic [WIDTH-1:0] w_sum_i;

      if (s == 0) begin : g_first
         // Subtraction is a + ~b + 1; cin acts as an active-high borrow-in.
         assign w_up_valid = bus.in_valid;
         assign w_a_i      = bus.a;
         assign w_b_i      = bus.sub ? ~bus.b : bus.b;
         assign w_c_i      = bus.cin ^ bus.sub;
         assign w_sum_i    = '0;
      end else begin : g_next
         assign w_up_valid = w_valid[s-1];
         assign w_a_i      = w_a[s-1];
         assign w_b_i      = w_b[s-1];
         assign w_c_i      = w_carry[s-1];
         assign w_sum_i    = w_sum[s-1];
      end

      // Unrolled form of ready_s = ~valid_s | ready_(s+1): a stage can
      // advance if the sink takes data or any stage at or below it is empty.
      assign w_ready[s] = bus.out_ready | ~(&w_valid[STAGES-1:s]);

      logic [SEG-1:0]  w_seg_a;
      logic [SEG-1:0]  w_seg_b;
      logic [SEG-1:0]  w_seg_sum;
      logic [NGRP-1:0] w_gg;
      logic [NGRP-1:0] w_gp;
      logic [NGRP-1:0] w_gc;
      logic [NGRP-1:0] w_gcout;

      assign w_seg_a = w_a_i[s*SEG +: SEG];
      assign w_seg_b = w_b_i[s*SEG +: SEG];

      for (genvar g = 0; g < NGRP; g++) begin : g_grp
         cla_group #(.GROUP(GROUP)) u_cla_group (
            .i_a    (w_seg_a[g*GROUP +: GROUP]),
            .i_b    (w_seg_b[g*GROUP +: GROUP]),
            .i_cin  (w_gc[g]),
            .o_sum  (w_seg_sum[g*GROUP +: GROUP]),
            .o_g    (w_gg[g]),
            .o_p    (w_gp[g]),
            .o_cout (w_gcout[g])
         );
      end

      // Group carry-ins from group G/P as flat sums of products.
      always_comb begin
         logic v_term;
         logic v_acc_p;
         w_gc    = '0;
         w_gc[0] = w_c_i;
         for (int g = 1; g < NGRP; g++) begin
            v_term  = 1'b0;
            v_acc_p = 1'b1;
            for (int j = g - 1; j >= 0; j--) begin
               v_term  = v_term | (v_acc_p & w_gg[j]);
               v_acc_p = v_acc_p & w_gp[j];
            end
            w_gc[g] = v_term | (v_acc_p & w_c_i);
         end
      end

      // Merge this segment's result into the partial sum travelling down.
      logic [WIDTH-1:0] w_sum_nxt;
      always_comb begin
         w_sum_nxt                = w_sum_i;
         w_sum_nxt[s*SEG +: SEG]  = w_seg_sum;
      end

      logic             r_valid;
      logic             r_carry;
      logic [WIDTH-1:0] r_sum;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // Stage register: data only moves with a real operation so the
      // outputs stay at zero from reset until the first result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_a     <= '0;
            r_b     <= '0;
         end else if (w_ready[s]) begin
            r_valid <= w_up_valid;
            if (w_up_valid) begin
               r_carry <= w_gcout[NGRP-1];
               r_sum   <= w_sum_nxt;
               r_a     <= w_a_i;
               r_b     <= w_b_i;
            end
         end
      end

      assign w_valid[s] = r_valid;
      assign w_carry[s] = r_carry;
      assign w_sum[s]   = r_sum;
      assign w_a[s]     = r_a;
      assign w_b[s]     = r_b;

`ifdef PIPELINED_CLA_FLAGS_EN
      if (s == STAGES - 1) begin : g_flags
         logic r_ovf;
         logic r_zero;
         logic w_ovf_nxt;
         logic w_zero_nxt;

         // Operand MSBs arrive here inside the last segment's a/b bits.
         assign w_ovf_nxt  = (w_a_i[WIDTH-1] == w_b_i[WIDTH-1]) &
                             (w_sum_nxt[WIDTH-1] != w_a_i[WIDTH-1]);
         assign w_zero_nxt = (w_sum_nxt == '0);

         // Flags load in lock-step with the final sum register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf  <= 1'b0;
               r_zero <= 1'b0;
            end else if (w_ready[s] && w_up_valid) begin
               r_ovf  <= w_ovf_nxt;
               r_zero <= w_zero_nxt;
            end
         end

         assign bus.ovf  = r_ovf;
         assign bus.zero = r_zero;
      end
`endif
   end

   assign bus.in_ready  = w_ready[0];
   assign bus.out_valid = w_valid[STAGES-1];
   assign bus.sum       = w_sum[STAGES-1];
   assign bus.cout      = w_carry[STAGES-1];

endmodule : pipelined_cla_adder
`default_nettype wire
